// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response, branch redirect and the decode handshake.
// master = fetch_queue side; slave = memory/branch/decode environment side.
// Ports: imem_req_*/imem_addr, imem_rsp_*, redirect_*, id_valid/id_ready/id_instr/id_pc/id_imm_op.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [4:0]  id_imm_op;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_imm_op,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_imm_op,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch: PC, pipelined imem reads, in-order instruction queue to decode.
// Latency: request accept -> memory response -> id_valid one cycle later.
// Backpressure: a queue slot is reserved per request, so requests stall when
//   queue occupancy + outstanding reads reaches FIFO_DEPTH; never drops a word.
// Ports: clk, rst (sync, active high); bus (fetch_queue_if.master) carries imem, redirect, id.
// Optional: define IMM_PREDECODE_EN to predecode the immediate class per entry;
//   otherwise id_imm_op is constant 0 and nothing extra is stored.
module fetch_queue #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

`ifdef IMM_PREDECODE_EN
  typedef struct packed {
    logic [4:0]  imm;
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  // One-hot immediate class {B, CB, I, Shift, D}; zero when none applies.
  function automatic logic [4:0] predecode(input logic [31:0] w);
    logic [4:0] r;
    r = 5'b00000;
    if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101)
      r = 5'b10000;
    else if (w[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100})
      r = 5'b01000;
    else if (w[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
                              10'b1001001000, 10'b1111001000, 10'b1011001000, 10'b1101001000})
      r = 5'b00100;
    else if (w[31:21] inside {11'b11010011010, 11'b11010011011})
      r = 5'b00010;
    else if (w[31:21] inside {11'b11111000010, 11'b11111000000, 11'b10111000100, 11'b10111000000,
                              11'b01111000010, 11'b01111000000, 11'b00111000010, 11'b00111000000})
      r = 5'b00001;
    return r;
  endfunction
`else
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;
`endif

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        head_q, head_d;
  entry_t        push_ent;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;

  logic        req_vld, accept, rsp, drop, push, pop;
  logic [31:0] sum_w;
  logic [63:0] redir_pc;
  logic        unused_redir_lo;

  // Low PC bits of a redirect are forced to zero.
  assign redir_pc        = {bus.redirect_pc[63:2], 2'b00};
  assign unused_redir_lo = ^bus.redirect_pc[1:0];

  always_comb begin
    sum_w      = 32'(count_q) + 32'(outst_q);
    req_vld    = !rst && !bus.redirect_valid &&
                 (32'(outst_q) < 32'(MAX_OUTSTANDING)) && (sum_w < 32'(FIFO_DEPTH));
    accept     = req_vld && bus.imem_req_ready;
    rsp        = bus.imem_rsp_valid;
    drop       = rsp && (discard_q != '0);
    push       = rsp && (discard_q == '0) && !bus.redirect_valid;
    pop        = (count_q != '0) && bus.id_ready && !bus.redirect_valid;
    outst_d    = outst_q + OW'(accept) - OW'(rsp);

    push_ent       = '0;
    push_ent.pc    = rsp_pc_q;
    push_ent.instr = bus.imem_rsp_data;
`ifdef IMM_PREDECODE_EN
    push_ent.imm   = predecode(bus.imem_rsp_data);
`endif

    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;

    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path,
      // including a response arriving right now (it is simply not pushed).
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = outst_d;
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
    end else begin
      count_d   = count_q + CW'(push) - CW'(pop);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      wr_ptr_d  = wr_ptr_q + AW'(push);
      discard_d = discard_q - OW'(drop);
      if (accept) fetch_pc_d = fetch_pc_q + 64'd4;
      if (push)   rsp_pc_d   = rsp_pc_q + 64'd4;
      // Head register tracks the entry at the new read pointer. When that slot
      // is the one being written this edge, take the incoming word directly.
      if (count_d != '0) begin
        if (push && (rd_ptr_d == wr_ptr_q)) head_d = push_ent;
        else                                 head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= push_ent;
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_addr      = fetch_pc_q;
  assign bus.id_valid       = (count_q != '0);
  assign bus.id_instr       = head_q.instr;
  assign bus.id_pc          = head_q.pc;
`ifdef IMM_PREDECODE_EN
  assign bus.id_imm_op      = head_q.imm;
`else
  assign bus.id_imm_op      = 5'b00000;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: transaction-level model (in-flight request list with squash
// flags, expected instruction queue) checked every cycle, plus directed literal checks.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  imm;
  } ent_t;

  ent_t        mq[$];
  ent_t        last_ent;
  logic [63:0] if_addr[$];
  bit          if_sq[$];
  int          if_due[$];
  logic [63:0] m_fetch;
  bit          known;

  bit          d_rst, d_ready, d_idready, d_redir, rnd_data;
  logic [63:0] d_rpc;
  int          lat_min, lat_max, cyc;

  logic [63:0] acc_addr[$];
  int          acc_cyc[$];
  logic [63:0] id_pc_log[$];
  logic [4:0]  id_imm_log[$];
  int          id_cyc[$];

  logic [31:0] tbl [8];
  logic [4:0]  exp5 [6];
  int          total, bad;

  function automatic bit mm(input logic [31:0] w, input logic [31:0] msk, input logic [31:0] val);
    return (w & msk) == val;
  endfunction

  function automatic logic [4:0] ref_imm(input logic [31:0] w);
    logic [4:0] r;
    r = 5'b0;
`ifdef IMM_PREDECODE_EN
    if (mm(w, 32'hFC000000, 32'h14000000) || mm(w, 32'hFC000000, 32'h94000000)) r = 5'b10000;
    else if (mm(w, 32'hFF000000, 32'hB4000000) || mm(w, 32'hFF000000, 32'hB5000000) ||
             mm(w, 32'hFF000000, 32'h54000000)) r = 5'b01000;
    else if (mm(w, 32'hFFC00000, 32'h91000000) || mm(w, 32'hFFC00000, 32'hB1000000) ||
             mm(w, 32'hFFC00000, 32'hD1000000) || mm(w, 32'hFFC00000, 32'hF1000000) ||
             mm(w, 32'hFFC00000, 32'h92000000) || mm(w, 32'hFFC00000, 32'hF2000000) ||
             mm(w, 32'hFFC00000, 32'hB2000000) || mm(w, 32'hFFC00000, 32'hD2000000)) r = 5'b00100;
    else if (mm(w, 32'hFFE00000, 32'hD3400000) || mm(w, 32'hFFE00000, 32'hD3600000)) r = 5'b00010;
    else if (mm(w, 32'hFFE00000, 32'hF8400000) || mm(w, 32'hFFE00000, 32'hF8000000) ||
             mm(w, 32'hFFE00000, 32'hB8800000) || mm(w, 32'hFFE00000, 32'hB8000000) ||
             mm(w, 32'hFFE00000, 32'h78400000) || mm(w, 32'hFFE00000, 32'h78000000) ||
             mm(w, 32'hFFE00000, 32'h38400000) || mm(w, 32'hFFE00000, 32'h38000000)) r = 5'b00001;
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_cyc.delete();
    id_pc_log.delete(); id_imm_log.delete(); id_cyc.delete();
  endtask

  // One clock cycle: drive, compare against the model, advance the model, cross the edge.
  task automatic step();
    bit          rsp, exp_req, popn, sq;
    logic [31:0] dat;
    logic [63:0] a;
    ent_t        cur, ne;
    rsp = !d_rst && (if_addr.size() > 0) && (if_due[0] <= cyc);
    dat = 32'h0;
    if (rsp) begin
      a   = if_addr[0];
      dat = (rnd_data && $urandom_range(0, 3) == 0) ? $urandom : tbl[a[4:2]];
    end
    rst                = d_rst;
    bus.imem_req_ready = d_ready;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = dat;
    bus.redirect_valid = d_redir;
    bus.redirect_pc    = d_rpc;
    bus.id_ready       = d_idready;
    #1;
    exp_req = !d_rst && !d_redir && (if_addr.size() < MAXO) && ((mq.size() + if_addr.size()) < DEPTH);
    chk("req_valid", bus.imem_req_valid, exp_req);
    if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
    if (known) begin
      cur = (mq.size() != 0) ? mq[0] : last_ent;
      chk("id_valid", bus.id_valid, mq.size() != 0);
      chk("id_pc", bus.id_pc, cur.pc);
      chk("id_instr", bus.id_instr, cur.instr);
      chk("id_imm_op", bus.id_imm_op, cur.imm);
    end
    if (bus.imem_req_valid && d_ready) begin
      acc_addr.push_back(bus.imem_addr); acc_cyc.push_back(cyc);
    end
    if (bus.id_valid && d_idready && !d_redir && !d_rst) begin
      id_pc_log.push_back(bus.id_pc); id_imm_log.push_back(bus.id_imm_op); id_cyc.push_back(cyc);
    end
    if (d_rst) begin
      mq.delete(); if_addr.delete(); if_sq.delete(); if_due.delete();
      m_fetch = RPC; last_ent = '0; known = 1;
    end else begin
      if (mq.size() != 0) last_ent = mq[0];
      popn = (mq.size() != 0) && d_idready && !d_redir;
      if (popn) void'(mq.pop_front());
      if (rsp) begin
        a  = if_addr.pop_front();
        sq = if_sq.pop_front();
        void'(if_due.pop_front());
        if (!sq) begin
          ne.pc = a; ne.instr = dat; ne.imm = ref_imm(dat);
          mq.push_back(ne);
        end
      end
      if (exp_req && d_ready) begin
        if_addr.push_back(m_fetch); if_sq.push_back(1'b0);
        if_due.push_back(cyc + $urandom_range(lat_min, lat_max));
        m_fetch = m_fetch + 64'd4;
      end
      if (d_redir) begin
        mq.delete();
        foreach (if_sq[i]) if_sq[i] = 1'b1;
        m_fetch = {d_rpc[63:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; known = 0;
    d_rst = 1; d_ready = 0; d_idready = 0; d_redir = 0; d_rpc = '0; rnd_data = 0;
    lat_min = 1; lat_max = 1; m_fetch = RPC; last_ent = '0;
    tbl[0] = 32'h14000001; tbl[1] = 32'hB4000020; tbl[2] = 32'h91000400; tbl[3] = 32'hD3600400;
    tbl[4] = 32'hF8400000; tbl[5] = 32'h8B000000; tbl[6] = 32'hD3400C00; tbl[7] = 32'h38000000;
`ifdef IMM_PREDECODE_EN
    exp5[0] = 5'b10000; exp5[1] = 5'b01000; exp5[2] = 5'b00100;
    exp5[3] = 5'b00010; exp5[4] = 5'b00001; exp5[5] = 5'b00000;
`else
    foreach (exp5[i]) exp5[i] = 5'b00000;
`endif
    #1;
    run(2);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_id_instr", bus.id_instr, 0);
    chk("rst_id_imm", bus.id_imm_op, 0);
    chk("rst_req_valid", bus.imem_req_valid, 0);

    // 1: streaming at one instruction per cycle.
    d_rst = 0; d_ready = 1; d_idready = 1;
    clear_logs();
    run(10);
    chk("t1_acc0", acc_addr[0], 64'h0);
    chk("t1_acc1", acc_addr[1], 64'h4);
    chk("t1_acc2", acc_addr[2], 64'h8);
    chk("t1_acc3", acc_addr[3], 64'hC);
    chk("t1_id_pc0", id_pc_log[0], 64'h0);
    chk("t1_id_pc1", id_pc_log[1], 64'h4);
    chk("t1_id_pc2", id_pc_log[2], 64'h8);
    chk("t1_latency", 64'(id_cyc[0] - acc_cyc[0]), 2);
    chk("t1_rate", 64'(id_cyc[3] - id_cyc[0]), 3);

    // 2: decode stalled -> queue fills, requests stop, then drains in order.
    d_idready = 0;
    run(10);
    chk("t2_queued", mq.size(), DEPTH);
    chk("t2_req_blocked", bus.imem_req_valid, 0);
    chk("t2_id_valid", bus.id_valid, 1);
    clear_logs();
    d_idready = 1;
    run(6);
    for (int k = 0; k < 3; k++) chk("t2_drain_order", id_pc_log[k+1] - id_pc_log[k], 64'h4);

    // 3: redirect with two reads in flight.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && if_addr.size() != 2; k++) step();
    chk("t3_two_inflight", if_addr.size(), 2);
    d_redir = 1; d_rpc = 64'h103;
    step();
    d_redir = 0;
    clear_logs();
    run(12);
    chk("t3_first_addr", acc_addr[0], 64'h100);
    chk("t3_first_id_pc", id_pc_log[0], 64'h100);

    // 4: redirect coinciding with a response and a pop.
    lat_min = 2; lat_max = 2; d_idready = 0;
    for (int k = 0; k < 20 && !(mq.size() > 0 && if_addr.size() > 0 && if_due[0] == cyc); k++) step();
    chk("t4_setup", (mq.size() > 0 && if_addr.size() > 0 && if_due[0] == cyc), 1);
    d_redir = 1; d_idready = 1; d_rpc = 64'h400;
    step();
    d_redir = 0;
    chk("t4_id_valid_after", bus.id_valid, 0);
    run(4);

    // 5: immediate-class predecode on a known instruction sequence.
    lat_min = 1; lat_max = 1;
    d_redir = 1; d_rpc = 64'h200;
    step();
    d_redir = 0;
    clear_logs();
    run(14);
    chk("t5_first_pc", id_pc_log[0], 64'h200);
    for (int k = 0; k < 6; k++) chk("t5_imm_op", id_imm_log[k], exp5[k]);

    // 6: reset while queue holds words and reads are in flight.
    lat_min = 3; lat_max = 3; d_idready = 0;
    for (int k = 0; k < 20 && !(mq.size() >= 2 && if_addr.size() > 0); k++) step();
    chk("t6_setup", (mq.size() >= 2 && if_addr.size() > 0), 1);
    d_rst = 1;
    step();
    chk("t6_id_valid", bus.id_valid, 0);
    chk("t6_id_pc", bus.id_pc, 0);
    chk("t6_id_instr", bus.id_instr, 0);
    chk("t6_id_imm", bus.id_imm_op, 0);
    chk("t6_req_valid", bus.imem_req_valid, 0);
    d_rst = 0; d_idready = 1; lat_min = 1; lat_max = 1;
    clear_logs();
    run(6);
    chk("t6_restart_addr", acc_addr[0], RPC);
    chk("t6_restart_pc", id_pc_log[0], RPC);

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 4; rnd_data = 1;
    for (int c = 0; c < 3000; c++) begin
      d_ready   = ($urandom_range(0, 3) != 0);
      d_idready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      d_redir   = ($urandom_range(0, 31) == 0);
      d_rst     = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 3))
        0:       d_rpc = {$urandom, $urandom};
        1:       d_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: d_rpc = 64'($urandom_range(0, 1023));
      endcase
      step();
    end
    d_rst = 0; d_redir = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
